kb_game_ctrl: RTL

Keyboard-to-game control decoder for the drag-racing design. It sits directly downstream of the PS/2 keyboard front end and consumes its decoded scan-code events (`code_new`, `key_pressed`, `key_code`). It turns those events into the game's control signals:
- held levels for throttle and clutch;
- single-cycle pulses for gear shifts and start;
- a pause toggle.

Shift pulses are rate-limited, and keyboard typematic repeats are filtered out.

---
 rtl/kb_game_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/kb_game_ctrl.sv
// Keyboard-to-game control decoder: turns PS/2 make/break events into held levels,
// single-cycle pulses, a pause toggle, and a shared rate limit on gear shifts.
module kb_game_ctrl #(
  parameter int unsigned SHIFT_LOCK = 6_500_000,
  parameter int unsigned LOCK_W     = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_new,
  input  logic       key_pressed,
  input  logic [7:0] key_code,
  output logic       throttle,
  output logic       clutch,
  output logic       shift_up,
  output logic       shift_down,
  output logic       start,
  output logic       pause
);

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_E     = 8'h24;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(SHIFT_LOCK);

  logic throttle_q, throttle_d;
  logic clutch_q, clutch_d;
  logic shift_up_q, shift_up_d;
  logic shift_down_q, shift_down_d;
  logic start_q, start_d;
  logic pause_q, pause_d;
  logic dn_e_q, dn_e_d;
  logic dn_q_q, dn_q_d;
  logic dn_ent_q, dn_ent_d;
  logic dn_esc_q, dn_esc_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic shift_ok;

  assign shift_ok = (lock_cnt_q == '0);

  always_comb begin
    throttle_d   = throttle_q;
    clutch_d     = clutch_q;
    shift_up_d   = 1'b0;
    shift_down_d = 1'b0;
    start_d      = 1'b0;
    pause_d      = pause_q;
    dn_e_d       = dn_e_q;
    dn_q_d       = dn_q_q;
    dn_ent_d     = dn_ent_q;
    dn_esc_d     = dn_esc_q;

    if (code_new) begin
      unique case (key_code)
        KEY_W:     throttle_d = key_pressed;
        KEY_SPACE: clutch_d   = key_pressed;
        KEY_E: begin
          // latch is set even when the lockout drops the press, so repeats never fire late
          if (key_pressed && !dn_e_q) shift_up_d = shift_ok;
          dn_e_d = key_pressed;
        end
        KEY_Q: begin
          if (key_pressed && !dn_q_q) shift_down_d = shift_ok;
          dn_q_d = key_pressed;
        end
        KEY_ENTER: begin
          if (key_pressed && !dn_ent_q) begin
            start_d = 1'b1;
            pause_d = 1'b0;
          end
          dn_ent_d = key_pressed;
        end
        KEY_ESC: begin
          if (key_pressed && !dn_esc_q) pause_d = ~pause_q;
          dn_esc_d = key_pressed;
        end
        default: ;
      endcase
    end

    if (shift_up_d || shift_down_d) lock_cnt_d = LOCK_LOAD;
    else if (!shift_ok)             lock_cnt_d = lock_cnt_q - 1'b1;
    else                            lock_cnt_d = lock_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      throttle_q   <= 1'b0;
      clutch_q     <= 1'b0;
      shift_up_q   <= 1'b0;
      shift_down_q <= 1'b0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      dn_e_q       <= 1'b0;
      dn_q_q       <= 1'b0;
      dn_ent_q     <= 1'b0;
      dn_esc_q     <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      throttle_q   <= throttle_d;
      clutch_q     <= clutch_d;
      shift_up_q   <= shift_up_d;
      shift_down_q <= shift_down_d;
      start_q      <= start_d;
      pause_q      <= pause_d;
      dn_e_q       <= dn_e_d;
      dn_q_q       <= dn_q_d;
      dn_ent_q     <= dn_ent_d;
      dn_esc_q     <= dn_esc_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  assign throttle   = throttle_q;
  assign clutch     = clutch_q;
  assign shift_up   = shift_up_q;
  assign shift_down = shift_down_q;
  assign start      = start_q;
  assign pause      = pause_q;

endmodule
